// File: rtl/dplca_id_alloc_if.sv
// Claim-table read port and claim write handshake between the ID allocator and the claim table.
interface dplca_id_alloc_if;
  logic [7:0] tbl_rd_addr;
  logic [1:0] tbl_rd_data;
  logic       claim_req;
  logic       claim_ack;
  logic [7:0] claim_id;

  modport master (
    output tbl_rd_addr,
    input  tbl_rd_data,
    output claim_req,
    input  claim_ack,
    output claim_id
  );

  modport slave (
    input  tbl_rd_addr,
    output tbl_rd_data,
    input  claim_req,
    output claim_ack,
    input  claim_id
  );
endinterface

// File: rtl/dplca_id_alloc.sv
// PLCA TXOP ID allocator: scans the claim table for a free ID, claims it, holds it
// through a number of table updates without conflict, then commits it as the local ID.
//
// state  | meaning
// IDLE   | allocator off or waiting for an aging pulse
// SCAN   | reading claim table entries looking for NONE
// CLAIM  | requesting a HARD write at claim_id
// HOLD   | counting table updates without conflict
// ACTIVE | claim_id committed as local node ID
// NO_ID  | last scan found no free ID
module dplca_id_alloc (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dplca_en,
  input  logic                   dplca_new_age,
  input  logic                   dplca_txop_table_upd,
  input  logic                   conflict,
  input  logic [7:0]             max_id,
  input  logic [7:0]             hold_cycles,
  dplca_id_alloc_if.master       bus,
  output logic                   id_valid,
  output logic                   no_id_err,
  output logic [2:0]             alloc_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    SCAN   = 3'b001,
    CLAIM  = 3'b010,
    HOLD   = 3'b011,
    ACTIVE = 3'b100,
    NO_ID  = 3'b101
  } state_t;

  localparam logic [1:0] ENTRY_NONE = 2'b10;

  state_t     state, state_nxt;
  logic [7:0] start_ptr, rd_ptr, rd_addr_q, issued, examined, hold_cnt, claim_id_q;
  logic       rd_vld;
  logic       hit, miss_all, issue;
  logic [7:0] hold_inc, conflict_ptr, ptr_src, scan_first;

  // A returned NONE stops further issue so the read sequence ends at the free entry.
  assign hit      = (state == SCAN) && rd_vld && (bus.tbl_rd_data == ENTRY_NONE);
  assign miss_all = (state == SCAN) &&
                    ((max_id == 8'd0) ||
                     (rd_vld && !hit && (({1'b0, examined} + 9'd1) == {1'b0, max_id})));
  assign issue    = (state == SCAN) && dplca_en && (issued < max_id) && !hit;

  assign hold_inc     = (dplca_txop_table_upd && (hold_cnt != 8'hFF)) ? hold_cnt + 8'd1 : hold_cnt;
  assign conflict_ptr = (claim_id_q >= max_id) ? 8'd1 : claim_id_q + 8'd1;
  assign ptr_src      = ((state == HOLD) || (state == ACTIVE)) ? conflict_ptr : start_ptr;
  assign scan_first   = ((ptr_src == 8'd0) || (ptr_src > max_id)) ? 8'd1 : ptr_src;

  always_comb begin
    state_nxt = state;
    if (!dplca_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (dplca_new_age) state_nxt = SCAN;
        SCAN:    if (hit) state_nxt = CLAIM;
                 else if (miss_all) state_nxt = NO_ID;
        CLAIM:   if (bus.claim_ack) state_nxt = HOLD;
        HOLD:    if (conflict) state_nxt = SCAN;
                 else if (hold_inc >= hold_cycles) state_nxt = ACTIVE;
        ACTIVE:  if (conflict) state_nxt = SCAN;
        NO_ID:   if (dplca_new_age) state_nxt = SCAN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      start_ptr  <= 8'd1;
      rd_ptr     <= 8'd1;
      rd_addr_q  <= 8'd0;
      rd_vld     <= 1'b0;
      issued     <= 8'd0;
      examined   <= 8'd0;
      hold_cnt   <= 8'd0;
      claim_id_q <= 8'd0;
    end else begin
      state  <= state_nxt;
      rd_vld <= issue;
      if (issue) begin
        rd_addr_q <= rd_ptr;
        rd_ptr    <= (rd_ptr >= max_id) ? 8'd1 : rd_ptr + 8'd1;
        issued    <= issued + 8'd1;
      end
      if ((state == SCAN) && rd_vld && !hit)
        examined <= examined + 8'd1;
      if ((state == SCAN) && (state_nxt == CLAIM))
        claim_id_q <= rd_addr_q;
      if ((state == CLAIM) && bus.claim_ack)
        hold_cnt <= 8'd0;
      else if (state == HOLD)
        hold_cnt <= hold_inc;
      // Scan entry overrides the per-cycle scan bookkeeping above.
      if ((state_nxt == SCAN) && (state != SCAN)) begin
        rd_ptr   <= scan_first;
        issued   <= 8'd0;
        examined <= 8'd0;
        rd_vld   <= 1'b0;
        if ((state == HOLD) || (state == ACTIVE))
          start_ptr <= conflict_ptr;
      end
    end
  end

  assign bus.tbl_rd_addr = issue ? rd_ptr : 8'd0;
  assign bus.claim_req   = (state == CLAIM);
  assign bus.claim_id    = claim_id_q;
  assign id_valid        = (state == ACTIVE);
  assign no_id_err       = (state == NO_ID);
  assign alloc_state     = state;

endmodule

// File: tb/tb_dplca_id_alloc.sv
// Self-checking bench for dplca_id_alloc: scenario table plus hand-written corner sequences,
// with expected claim-table read addresses checked through a queue.
module tb_dplca_id_alloc;

  localparam logic [1:0] S = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] R = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       dplca_en;
  logic       dplca_new_age;
  logic       dplca_txop_table_upd;
  logic       conflict;
  logic [7:0] max_id;
  logic [7:0] hold_cycles;
  logic       id_valid;
  logic       no_id_err;
  logic [2:0] alloc_state;

  dplca_id_alloc_if bus ();

  dplca_id_alloc dut (
    .clk                  (clk),
    .reset                (reset),
    .dplca_en             (dplca_en),
    .dplca_new_age        (dplca_new_age),
    .dplca_txop_table_upd (dplca_txop_table_upd),
    .conflict             (conflict),
    .max_id               (max_id),
    .hold_cycles          (hold_cycles),
    .bus                  (bus.master),
    .id_valid             (id_valid),
    .no_id_err            (no_id_err),
    .alloc_state          (alloc_state)
  );

  always #5 clk = ~clk;

  logic [1:0] tbl [256];
  always @(posedge clk) bus.tbl_rd_data <= tbl[bus.tbl_rd_addr];

  int n_vec = 0;
  int n_err = 0;
  int exp_q [$];

  typedef struct {
    logic [7:0]      max_id;
    logic [7:0]      hold;
    logic [7:0][1:0] ent;
    int              nreads;
    logic [7:0]      claim;
    bit              noid;
  } row_t;

  row_t rows [7];

  always @(negedge clk) begin
    if (!reset && bus.tbl_rd_addr != 8'd0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: got addr %0d, required no read", bus.tbl_rd_addr);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(bus.tbl_rd_addr) != e) begin
          n_err++;
          $display("FAIL read_addr: got %0d, required %0d", bus.tbl_rd_addr, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dplca_en = 1'b0;
    dplca_new_age = 1'b0;
    dplca_txop_table_upd = 1'b0;
    conflict = 1'b0;
    bus.claim_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_table(input logic [7:0][1:0] ent);
    for (int i = 0; i < 256; i++) tbl[i] = H;
    for (int i = 1; i <= 8; i++) tbl[i] = ent[i-1];
  endtask

  task automatic push_reads(input int first, input int n, input int maxv);
    int a;
    a = first;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(a);
      a = (a >= maxv) ? 1 : a + 1;
    end
  endtask

  task automatic wait_settle();
    int n;
    n = 0;
    while (alloc_state != 3'b010 && alloc_state != 3'b101 && n < 300) begin
      tick();
      n++;
    end
    chk("settle_within_budget", int'(n < 300), 1);
  endtask

  task automatic pulse_new_age();
    dplca_new_age = 1'b1;
    tick();
    dplca_new_age = 1'b0;
  endtask

  task automatic ack_claim();
    bus.claim_ack = 1'b1;
    tick();
    bus.claim_ack = 1'b0;
    chk("hold_state", alloc_state, 3);
    chk("claim_req_cleared", bus.claim_req, 0);
  endtask

  task automatic run_row(input int idx);
    row_t r;
    r = rows[idx];
    do_reset();
    max_id = r.max_id;
    hold_cycles = r.hold;
    load_table(r.ent);
    dplca_en = 1'b1;
    push_reads(1, r.nreads, r.max_id);
    pulse_new_age();
    wait_settle();
    chk("reads_all_seen", exp_q.size(), 0);
    if (r.noid) begin
      chk("no_id_state", alloc_state, 5);
      chk("no_id_err", no_id_err, 1);
      chk("noid_id_valid", id_valid, 0);
    end else begin
      chk("claim_id", bus.claim_id, r.claim);
      chk("claim_req", bus.claim_req, 1);
      tick();
      tick();
      chk("claim_req_held", bus.claim_req, 1);
      ack_claim();
      for (int i = 0; i < r.hold; i++) begin
        chk("id_valid_before_hold", id_valid, 0);
        dplca_txop_table_upd = 1'b1;
        tick();
        dplca_txop_table_upd = 1'b0;
      end
      if (r.hold == 0) tick();
      chk("active_state", alloc_state, 4);
      chk("id_valid", id_valid, 1);
      chk("claim_id_stable", bus.claim_id, r.claim);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{8'd4, 8'd2, {H,H,H,H,N,N,S,H}, 3, 8'd3, 1'b0};
    rows[1] = '{8'd3, 8'd1, {H,H,H,H,H,H,H,H}, 3, 8'd0, 1'b1};
    rows[2] = '{8'd5, 8'd0, {H,H,H,H,H,H,H,N}, 1, 8'd1, 1'b0};
    rows[3] = '{8'd4, 8'd1, {H,H,H,H,N,S,H,R}, 4, 8'd4, 1'b0};
    rows[4] = '{8'd0, 8'd1, {N,N,N,N,N,N,N,N}, 0, 8'd0, 1'b1};
    rows[5] = '{8'd2, 8'd1, {H,H,H,H,H,N,H,H}, 2, 8'd0, 1'b1};
    rows[6] = '{8'd8, 8'd3, {N,H,H,H,H,H,H,H}, 8, 8'd8, 1'b0};

    max_id = 8'd4;
    hold_cycles = 8'd0;
    load_table({H,H,H,H,H,H,H,H});
    do_reset();
    chk("reset_state", alloc_state, 0);
    chk("reset_claim_req", bus.claim_req, 0);
    chk("reset_claim_id", bus.claim_id, 0);
    chk("reset_rd_addr", bus.tbl_rd_addr, 0);
    chk("reset_id_valid", id_valid, 0);
    chk("reset_no_id_err", no_id_err, 0);

    for (int i = 0; i < 7; i++) run_row(i);

    // Committed ID 4 of 4: aging ignored, conflict rescans from ID 1.
    do_reset();
    max_id = 8'd4;
    hold_cycles = 8'd0;
    load_table({H,H,H,H,N,H,H,H});
    dplca_en = 1'b1;
    push_reads(1, 4, 4);
    pulse_new_age();
    wait_settle();
    chk("wrap_claim_id", bus.claim_id, 4);
    ack_claim();
    tick();
    chk("wrap_active", alloc_state, 4);
    pulse_new_age();
    chk("new_age_in_active_ignored", alloc_state, 4);
    push_reads(1, 4, 4);
    conflict = 1'b1;
    tick();
    conflict = 1'b0;
    chk("conflict_to_scan", alloc_state, 1);
    chk("conflict_id_valid", id_valid, 0);
    wait_settle();
    chk("rescan_reads_seen", exp_q.size(), 0);
    chk("rescan_claim_id", bus.claim_id, 4);

    // Conflict together with a table update in HOLD: conflict wins, rescan from claim_id+1.
    do_reset();
    max_id = 8'd4;
    hold_cycles = 8'd1;
    load_table({H,H,H,H,H,N,N,H});
    dplca_en = 1'b1;
    push_reads(1, 2, 4);
    pulse_new_age();
    wait_settle();
    chk("hold_conf_claim", bus.claim_id, 2);
    ack_claim();
    push_reads(3, 1, 4);
    conflict = 1'b1;
    dplca_txop_table_upd = 1'b1;
    tick();
    conflict = 1'b0;
    dplca_txop_table_upd = 1'b0;
    chk("conflict_beats_upd", alloc_state, 1);
    wait_settle();
    chk("next_ptr_reads_seen", exp_q.size(), 0);
    chk("next_ptr_claim", bus.claim_id, 3);
    chk("in_claim_before_reset", bus.claim_req, 1);

    // Reset mid-claim with claim_ack pending.
    reset = 1'b1;
    bus.claim_ack = 1'b1;
    tick();
    chk("rst_claim_state", alloc_state, 0);
    chk("rst_claim_req", bus.claim_req, 0);
    chk("rst_claim_id", bus.claim_id, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_no_id_err", no_id_err, 0);
    chk("rst_rd_addr", bus.tbl_rd_addr, 0);
    reset = 1'b0;
    tick();
    bus.claim_ack = 1'b0;
    chk("ack_after_reset_ignored", alloc_state, 0);
    push_reads(1, 2, 4);
    pulse_new_age();
    wait_settle();
    chk("start_ptr_reset_reads", exp_q.size(), 0);
    chk("start_ptr_reset_claim", bus.claim_id, 2);

    // NO_ID ignores conflict; next aging pulse rescans (held high, must not restart).
    do_reset();
    max_id = 8'd3;
    hold_cycles = 8'd5;
    load_table({H,H,H,H,H,H,H,H});
    dplca_en = 1'b1;
    push_reads(1, 3, 3);
    pulse_new_age();
    wait_settle();
    chk("noid_err_set", no_id_err, 1);
    conflict = 1'b1;
    tick();
    conflict = 1'b0;
    chk("conflict_in_noid_ignored", alloc_state, 5);
    tbl[2] = N;
    push_reads(1, 2, 3);
    dplca_new_age = 1'b1;
    tick();
    chk("noid_cleared", no_id_err, 0);
    chk("noid_rescan", alloc_state, 1);
    tick();
    dplca_new_age = 1'b0;
    wait_settle();
    chk("rescan_noid_reads", exp_q.size(), 0);
    chk("rescan_noid_claim", bus.claim_id, 2);
    ack_claim();
    dplca_en = 1'b0;
    tick();
    chk("disable_state", alloc_state, 0);
    chk("disable_claim_req", bus.claim_req, 0);
    chk("disable_id_valid", id_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dplca_id_alloc.md
DPLCA_ID_ALLOC -- requirements
Module: dplca_id_alloc

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port dplca_en, input, 1, allocator enable; 0 forces IDLE next cycle.
REQ-004 SHALL have port dplca_new_age, input, 1, one-cycle pulse from aging FSM; starts a scan.
REQ-005 SHALL have port dplca_txop_table_upd, input, 1, pulse per TXOP table update; counted in HOLD.
REQ-006 SHALL have port conflict, input, 1, another node claimed the ID currently held by this node.
REQ-007 SHALL have port max_id, input, 8, highest eligible TXOP ID; ID 0 never eligible (coordinator).
REQ-008 SHALL have port hold_cycles, input, 8, table updates required without conflict before commit.
REQ-009 SHALL have port tbl_rd_addr, output, 8, claim table read address.
REQ-010 SHALL have port tbl_rd_data, input, 2, claim entry, one-cycle latency; SOFT=00, HARD=01, NONE=10.
REQ-011 SHALL have port claim_req, output, 1, request to write HARD at claim_id.
REQ-012 SHALL have port claim_ack, input, 1, claim write done.
REQ-013 SHALL have port claim_id, output, 8, selected TXOP ID.
REQ-014 SHALL have port id_valid, output, 1, claim_id committed as local node ID.
REQ-015 SHALL have port no_id_err, output, 1, scan found no free ID.
REQ-016 SHALL have port alloc_state, output, 3, current FSM state.

Function
REQ-017 SHALL implement states IDLE=000, SCAN=001, CLAIM=010, HOLD=011, ACTIVE=100, NO_ID=101.
REQ-018 IDLE SHALL go to SCAN on dplca_new_age=1 with dplca_en=1; NO_ID likewise re-enters SCAN.
REQ-019 SCAN SHALL issue one address per cycle starting at start_ptr, increment, wrap from max_id to 1, data checked one cycle after issue.
REQ-020 First returned entry equal to NONE SHALL be latched into claim_id and FSM SHALL go to CLAIM the next cycle; in-flight read discarded.
REQ-021 SOFT, HARD and reserved 11 entries SHALL be treated as occupied.
REQ-022 After max_id entries examined without NONE, FSM SHALL enter NO_ID and assert no_id_err until the next scan starts.
REQ-023 max_id=0 SHALL send SCAN directly to NO_ID in one cycle with no reads counted.
REQ-024 CLAIM SHALL hold claim_req=1 until the cycle claim_ack=1, then clear it and enter HOLD; hold counter cleared.
REQ-025 HOLD SHALL count dplca_txop_table_upd pulses (8-bit, saturating); count reaching hold_cycles SHALL enter ACTIVE; hold_cycles=0 enters ACTIVE the cycle after HOLD entry.
REQ-026 id_valid SHALL be 1 only in ACTIVE; claim_id stable while in CLAIM, HOLD, ACTIVE.
REQ-027 conflict=1 in HOLD or ACTIVE SHALL clear id_valid, set start_ptr=claim_id+1 (wrap to 1 beyond max_id), and enter SCAN next cycle.
REQ-028 conflict in IDLE, SCAN, CLAIM, NO_ID SHALL be ignored.
REQ-029 dplca_new_age in ACTIVE SHALL be ignored; dplca_new_age during SCAN SHALL not restart scan.
REQ-030 Conflict and dplca_txop_table_upd in the same HOLD cycle: conflict SHALL win.
REQ-031 dplca_en=0 in any state SHALL enter IDLE next cycle, drop claim_req, id_valid, no_id_err; start_ptr kept.
REQ-032 tbl_rd_addr SHALL be 0 outside SCAN.

Reset
REQ-033 reset=1 SHALL on the next edge set state IDLE, start_ptr=1, claim_id=0, tbl_rd_addr=0, hold counter=0, scan counter=0, claim_req=0, id_valid=0, no_id_err=0.
REQ-034 Reset SHALL override every input including mid-scan and mid-claim; claim_ack after reset SHALL be ignored.

Verification
REQ-035 max_id=4, table {1:HARD,2:SOFT,3:NONE,4:NONE}, new_age pulse -> reads 1,2,3; claim_id=3; claim_req until ack.
REQ-036 hold_cycles=2, no conflict, two table_upd pulses -> ACTIVE, id_valid=1 the cycle after second pulse.
REQ-037 ACTIVE with claim_id=4, max_id=4, conflict pulse -> id_valid=0, SCAN starts at address 1.
REQ-038 max_id=3, all entries HARD -> exactly 3 reads, NO_ID, no_id_err=1; next new_age clears it and rescans.
REQ-039 Reset asserted mid-CLAIM with claim_req=1 -> next cycle all outputs zero, state IDLE, start_ptr=1.
